// File: rtl/shared_pkg.sv
// Shared UART types and constants: FSM state encoding, data width and
// the parity mode encoding used by both the transmitter and receiver.
package shared_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_states_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2
  } parity_mode_e;

  // MODE1 carries the inverted XOR of the data, MODE2 the plain XOR.
  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] data,
                                           input parity_mode_e mode);
    logic p;
    p = ^data;
    case (mode)
      MODE1:   return ~p;
      MODE2:   return p;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle for the UART receiver and its consumer.
interface uart_rx_if (
  input logic clk,
  input logic rst_n
);
  import shared_pkg::*;

  logic                  rx;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun_err;

  modport DUT (
    input  clk,
    input  rst_n,
    input  rx,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun_err
  );

endinterface

// File: rtl/uart_rx_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit with a
// configurable reset value (idle-high lines reset to 1).
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; only the last stage leaves this module.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the line, reassembles start/data/parity/stop
// frames and hands each word over a valid/ready interface with error flags.
module uart_rx
  import shared_pkg::*;
#(
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = $clog2(DATA_WIDTH) + 1;

  localparam logic [TW-1:0] TMR_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0] TMR_ONE    = TW'(1);
  localparam logic [TW-1:0] TMR_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMR_HALF   = TW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [BW-1:0] BIT_ZERO   = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);
  localparam parity_mode_e  PMODE      = parity_mode_e'(2'(PARITY_EN));

  uart_states_e          state_r, state_s;
  logic [TW-1:0]         tmr_r, tmr_s;
  logic [BW-1:0]         bit_r, bit_s;
  logic [DATA_WIDTH-1:0] shreg_r, shreg_s;
  logic                  perr_pend_r, perr_pend_s;
  logic                  ferr_pend_r, ferr_pend_s;
  logic                  armed_r, armed_s;
  logic [DATA_WIDTH-1:0] rx_data_s;
  logic                  rx_valid_s;
  logic                  parity_err_s;
  logic                  frame_err_s;
  logic                  overrun_err_s;
  logic                  rxs_s;

  sync_bit #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs_s)
  );

  // Next-state, datapath and handshake logic for the receive FSM.
  always_comb begin
    state_s       = state_r;
    tmr_s         = tmr_r;
    bit_s         = bit_r;
    shreg_s       = shreg_r;
    perr_pend_s   = perr_pend_r;
    ferr_pend_s   = ferr_pend_r;
    armed_s       = armed_r;
    rx_data_s     = rx_data;
    rx_valid_s    = rx_valid;
    parity_err_s  = parity_err;
    frame_err_s   = frame_err;
    overrun_err_s = 1'b0;

    case (state_r)
      // A start edge counts only after the line has been seen high, so a
      // stuck-low line produces a single framed word rather than a stream.
      IDLE: begin
        if (rxs_s) begin
          armed_s = 1'b1;
        end else if (armed_r) begin
          armed_s     = 1'b0;
          perr_pend_s = 1'b0;
          ferr_pend_s = 1'b0;
          bit_s       = BIT_ZERO;
          if (HALF == 0) begin
            state_s = DATA;
            tmr_s   = TMR_RELOAD;
          end else begin
            state_s = START;
            tmr_s   = TMR_HALF;
          end
        end else begin
          armed_s = 1'b0;
        end
      end

      START: begin
        if (tmr_r == TMR_ZERO) begin
          if (rxs_s) begin
            state_s = IDLE;
          end else begin
            state_s = DATA;
            tmr_s   = TMR_RELOAD;
          end
        end else begin
          tmr_s = tmr_r - TMR_ONE;
        end
      end

      // Right shift so the first (LSB) sample ends up in bit 0.
      DATA: begin
        if (tmr_r == TMR_ZERO) begin
          tmr_s   = TMR_RELOAD;
          shreg_s = {rxs_s, shreg_r[DATA_WIDTH-1:1]};
          if (bit_r == LAST_DATA) begin
            bit_s   = BIT_ZERO;
            state_s = (PMODE != NONE) ? PARITY : STOP;
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          tmr_s = tmr_r - TMR_ONE;
        end
      end

      PARITY: begin
        if (tmr_r == TMR_ZERO) begin
          tmr_s       = TMR_RELOAD;
          perr_pend_s = (rxs_s != expected_parity(shreg_r, PMODE));
          state_s     = STOP;
        end else begin
          tmr_s = tmr_r - TMR_ONE;
        end
      end

      STOP: begin
        if (tmr_r == TMR_ZERO) begin
          tmr_s = TMR_RELOAD;
          if (!rxs_s) begin
            ferr_pend_s = 1'b1;
          end else begin
            ferr_pend_s = ferr_pend_r;
          end
          if (bit_r == LAST_STOP) begin
            bit_s   = BIT_ZERO;
            state_s = DONE;
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          tmr_s = tmr_r - TMR_ONE;
        end
      end

      // A word still waiting to be taken wins; the new one is dropped.
      DONE: begin
        state_s = IDLE;
        if (!rx_valid || rx_ready) begin
          rx_data_s    = shreg_r;
          rx_valid_s   = 1'b1;
          parity_err_s = perr_pend_r;
          frame_err_s  = ferr_pend_r;
        end else begin
          overrun_err_s = 1'b1;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    if ((state_r != DONE) && rx_valid && rx_ready) begin
      rx_valid_s = 1'b0;
    end else begin
      rx_valid_s = rx_valid_s;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      tmr_r       <= TMR_ZERO;
      bit_r       <= BIT_ZERO;
      shreg_r     <= {DATA_WIDTH{1'b0}};
      perr_pend_r <= 1'b0;
      ferr_pend_r <= 1'b0;
      armed_r     <= 1'b0;
      rx_data     <= {DATA_WIDTH{1'b0}};
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state_r     <= state_s;
      tmr_r       <= tmr_s;
      bit_r       <= bit_s;
      shreg_r     <= shreg_s;
      perr_pend_r <= perr_pend_s;
      ferr_pend_r <= ferr_pend_s;
      armed_r     <= armed_s;
      rx_data     <= rx_data_s;
      rx_valid    <= rx_valid_s;
      parity_err  <= parity_err_s;
      frame_err   <= frame_err_s;
      overrun_err <= overrun_err_s;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: four receivers with different parameters,
// each fed hand-built serial frames; a negedge monitor checks every accepted word.
module tb_uart_rx;
  import shared_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q [4][$];
  int          words [4];
  int          ovr_cnt [4];
  int unsigned rise_cyc [4];
  logic        prev_v [4];
  int unsigned t0;
  int          w_before;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if b0 (.clk(clk), .rst_n(rst_n));
  uart_rx_if b1 (.clk(clk), .rst_n(rst_n));
  uart_rx_if b2 (.clk(clk), .rst_n(rst_n));
  uart_rx_if b3 (.clk(clk), .rst_n(rst_n));

  uart_rx d0 (
    .clk(clk), .rst_n(rst_n), .rx(b0.rx), .rx_data(b0.rx_data), .rx_valid(b0.rx_valid),
    .rx_ready(b0.rx_ready), .parity_err(b0.parity_err), .frame_err(b0.frame_err),
    .overrun_err(b0.overrun_err));

  uart_rx #(.PARITY_EN(1)) d1 (
    .clk(clk), .rst_n(rst_n), .rx(b1.rx), .rx_data(b1.rx_data), .rx_valid(b1.rx_valid),
    .rx_ready(b1.rx_ready), .parity_err(b1.parity_err), .frame_err(b1.frame_err),
    .overrun_err(b1.overrun_err));

  uart_rx #(.STOP_BITS(2)) d2 (
    .clk(clk), .rst_n(rst_n), .rx(b2.rx), .rx_data(b2.rx_data), .rx_valid(b2.rx_valid),
    .rx_ready(b2.rx_ready), .parity_err(b2.parity_err), .frame_err(b2.frame_err),
    .overrun_err(b2.overrun_err));

  uart_rx #(.CLKS_PER_BIT(4)) d3 (
    .clk(clk), .rst_n(rst_n), .rx(b3.rx), .rx_data(b3.rx_data), .rx_valid(b3.rx_valid),
    .rx_ready(b3.rx_ready), .parity_err(b3.parity_err), .frame_err(b3.frame_err),
    .overrun_err(b3.overrun_err));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, got, exp);
    end
  endtask

  task automatic expect_word(input int idx, input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q[idx].push_back(e);
  endtask

  task automatic mon(input int idx, input logic v, input logic r, input logic [7:0] d,
                     input logic pe, input logic fe, input logic ov);
    exp_t e;
    if (ov === 1'b1) ovr_cnt[idx]++;
    if (v === 1'b1 && prev_v[idx] !== 1'b1) rise_cyc[idx] = cyc;
    prev_v[idx] = v;
    if (v === 1'b1 && r === 1'b1) begin
      words[idx]++;
      if (exp_q[idx].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word%0d: unexpected word data=%h perr=%b ferr=%b", idx, d, pe, fe);
      end else begin
        e = exp_q[idx].pop_front();
        chk($sformatf("word%0d {data,perr,ferr}", idx), {22'd0, d, pe, fe},
            {22'd0, e.data, e.perr, e.ferr});
      end
    end
  endtask

  always @(negedge clk) mon(0, b0.rx_valid, b0.rx_ready, b0.rx_data, b0.parity_err, b0.frame_err, b0.overrun_err);
  always @(negedge clk) mon(1, b1.rx_valid, b1.rx_ready, b1.rx_data, b1.parity_err, b1.frame_err, b1.overrun_err);
  always @(negedge clk) mon(2, b2.rx_valid, b2.rx_ready, b2.rx_data, b2.parity_err, b2.frame_err, b2.overrun_err);
  always @(negedge clk) mon(3, b3.rx_valid, b3.rx_ready, b3.rx_data, b3.parity_err, b3.frame_err, b3.overrun_err);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int idx, input logic v);
    case (idx)
      0:       b0.rx = v;
      1:       b1.rx = v;
      2:       b2.rx = v;
      default: b3.rx = v;
    endcase
  endtask

  // Drives start, 8 data bits LSB first, optional parity, nstop stop bits
  // taken from stops[0..], then idle_v for two cycles.
  task automatic send(input int idx, input logic [7:0] d, input int cpb, input bit has_par,
                      input logic pbit, input int nstop, input logic [2:0] stops,
                      input logic idle_v, input int rst_at, output int unsigned start_cyc);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    start_cyc = cyc + 1;
    for (int i = 0; i < bits.size(); i++) begin
      set_rx(idx, bits[i]);
      rst_n = (i == rst_at) ? 1'b0 : 1'b1;
      tick(cpb);
    end
    rst_n = 1'b1;
    set_rx(idx, idle_v);
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      words[i] = 0;
      ovr_cnt[i] = 0;
      rise_cyc[i] = 0;
      prev_v[i] = 1'b0;
    end
    b0.rx = 1'b1; b1.rx = 1'b1; b2.rx = 1'b1; b3.rx = 1'b1;
    b0.rx_ready = 1'b1; b1.rx_ready = 1'b1; b2.rx_ready = 1'b1; b3.rx_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);

    chk("reset outputs d0", {21'd0, b0.rx_data, b0.rx_valid, b0.parity_err, b0.frame_err, b0.overrun_err}, 32'd0);
    chk("reset outputs d2", {21'd0, b2.rx_data, b2.rx_valid, b2.parity_err, b2.frame_err, b2.overrun_err}, 32'd0);

    // Default loopback and start-to-valid latency.
    expect_word(0, 8'hA5, 1'b0, 1'b0);
    send(0, 8'hA5, 1, 1'b0, 1'b0, 1, 3'b001, 1'b1, -1, t0);
    tick(10);
    chk("latency edges", rise_cyc[0] - t0, 32'd12);
    chk("a5 valid one cycle", {31'd0, b0.rx_valid}, 32'd0);

    // Odd-style parity: ^8'h03 = 0, so the correct parity bit is 1.
    expect_word(1, 8'h03, 1'b0, 1'b0);
    send(1, 8'h03, 1, 1'b1, 1'b1, 1, 3'b001, 1'b1, -1, t0);
    expect_word(1, 8'h03, 1'b1, 1'b0);
    send(1, 8'h03, 1, 1'b1, 1'b0, 1, 3'b001, 1'b1, -1, t0);
    tick(10);

    // Two stop bits, second low, line then stuck low.
    expect_word(2, 8'h3C, 1'b0, 1'b1);
    send(2, 8'h3C, 1, 1'b0, 1'b0, 2, 3'b001, 1'b0, -1, t0);
    tick(40);
    chk("stuck low words", words[2], 32'd1);
    set_rx(2, 1'b1);
    tick(4);
    expect_word(2, 8'h81, 1'b0, 1'b0);
    send(2, 8'h81, 1, 1'b0, 1'b0, 2, 3'b011, 1'b1, -1, t0);
    tick(10);
    chk("recovered words", words[2], 32'd2);

    // Overrun: consumer stalled across two back-to-back frames.
    b0.rx_ready = 1'b0;
    expect_word(0, 8'h11, 1'b0, 1'b0);
    send(0, 8'h11, 1, 1'b0, 1'b0, 1, 3'b001, 1'b1, -1, t0);
    send(0, 8'h22, 1, 1'b0, 1'b0, 1, 3'b001, 1'b1, -1, t0);
    tick(15);
    chk("overrun pulses", ovr_cnt[0], 32'd1);
    chk("held valid", {31'd0, b0.rx_valid}, 32'd1);
    chk("held data", {24'd0, b0.rx_data}, 32'h11);
    b0.rx_ready = 1'b1;
    tick(1);
    b0.rx_ready = 1'b0;
    chk("valid after accept", {31'd0, b0.rx_valid}, 32'd0);
    b0.rx_ready = 1'b1;

    // One-clock glitch at 4 clocks/bit, then a real frame.
    set_rx(3, 1'b0);
    tick(1);
    set_rx(3, 1'b1);
    tick(60);
    chk("glitch words", words[3], 32'd0);
    expect_word(3, 8'h5A, 1'b0, 1'b0);
    send(3, 8'h5A, 4, 1'b0, 1'b0, 1, 3'b001, 1'b1, -1, t0);
    tick(20);

    // Reset pulse during data bit 3 of an all-ones frame.
    w_before = words[0];
    send(0, 8'hFF, 1, 1'b0, 1'b0, 1, 3'b001, 1'b1, 4, t0);
    tick(10);
    chk("mid-frame reset outputs", {21'd0, b0.rx_data, b0.rx_valid, b0.parity_err, b0.frame_err, b0.overrun_err}, 32'd0);
    chk("mid-frame reset no word", words[0], w_before);
    expect_word(0, 8'hC3, 1'b0, 1'b0);
    send(0, 8'hC3, 1, 1'b0, 1'b0, 1, 3'b001, 1'b1, -1, t0);
    tick(15);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pending words d%0d", i), exp_q[i].size(), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
